// File: rtl/pipe_sequencer.sv
// pipe_sequencer
// Central pipeline controller for the 5-stage MIPS core. It produces the
// per-stage advance/squash strobes, detects load-use hazards and taken-branch
// flushes, and runs the RUN/HALT/STEP debug state machine.
//
// Optional feature macro: PIPE_STAT_EN builds the statistics counters.
// Without it, cycle_cnt/stall_cnt/flush_cnt are tied to zero.
//
// Ports
//   clk, rst          : pipeline clock, synchronous active-high reset
//   id_rs, id_rt      : source register fields of the instruction in ID
//   id_uses_rt        : ID instruction reads rt
//   ex_rt, ex_mem_read: destination rt / load flag of the instruction in EX
//   branch_taken      : branch/jump resolved taken in EX
//   halt_req          : syscall halt in EX
//   resume, step      : debug pulses
//   pc_en, *_go, *_clear : buffer enables (combinational)
//   state             : 0 RUN, 1 HALT, 2 STEP (registered)
//   cycle_cnt, stall_cnt, flush_cnt : saturating statistics
//
// state | meaning
// ------+---------------------------------------------------
// RUN   | normal execution, strobes follow hazard logic
// HALT  | pipeline frozen, all enables low
// STEP  | one active cycle, then back to HALT unless resumed
module pipe_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic        branch_taken,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        step,
  output logic        pc_en,
  output logic        if_id_go,
  output logic        if_id_clear,
  output logic        id_ex_go,
  output logic        id_ex_clear,
  output logic        ex_mem_go,
  output logic        mem_wb_go,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t cur;

  logic active;
  logic lu;
  logic lu_act;
  logic br_act;

  assign state  = cur;
  assign active = !rst && ((cur == RUN) || (cur == STEP));
  assign lu     = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  // Branch wins over load-use: the instruction that would stall is squashed.
  assign br_act = active && branch_taken;
  assign lu_act = active && lu && !branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= RUN;
    end else begin
      case (cur)
        RUN:     if (halt_req) cur <= HALT;
        HALT:    if (resume) cur <= RUN;
                 else if (step) cur <= STEP;
        STEP:    cur <= resume ? RUN : HALT;
        default: cur <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_go    = 1'b0;
    if_id_clear = 1'b0;
    id_ex_go    = 1'b0;
    id_ex_clear = 1'b0;
    ex_mem_go   = 1'b0;
    mem_wb_go   = 1'b0;
    if (rst) begin
      // Flush IF/ID and ID/EX to NOPs while holding the later stages.
      if_id_go    = 1'b1;
      id_ex_go    = 1'b1;
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
    end else if (active) begin
      pc_en     = 1'b1;
      if_id_go  = 1'b1;
      id_ex_go  = 1'b1;
      ex_mem_go = 1'b1;
      mem_wb_go = 1'b1;
      if (br_act) begin
        if_id_clear = 1'b1;
        id_ex_clear = 1'b1;
      end else if (lu_act) begin
        pc_en       = 1'b0;
        if_id_go    = 1'b0;
        id_ex_clear = 1'b1;
      end
    end
  end

`ifdef PIPE_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (active && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 32'd1;
      if (lu_act && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
      if (br_act && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Central pipeline controller for the 5-stage MIPS core. Generates the per-stage advance (`go`) and squash (`clear`) strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB buffers. Detects load-use hazards and taken-branch flushes, and runs a RUN/HALT/STEP debug state machine driven by syscall halt, resume and single-step requests. Sits beside the datapath: it consumes register-field and control bits from ID/EX and drives only buffer enables.

## Interface
- No parameters.
- `clk` in 1: pipeline clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_uses_rt` in 1: ID instruction reads rt as a source.
- `ex_rt` in 5: destination rt of the instruction in EX.
- `ex_mem_read` in 1: EX instruction is a load.
- `branch_taken` in 1: branch/jump resolved taken in EX this cycle.
- `halt_req` in 1: syscall-halt in EX this cycle.
- `resume` in 1: one-cycle pulse; leave HALT/STEP for RUN.
- `step` in 1: one-cycle pulse; execute one pipeline cycle from HALT.
- `pc_en` out 1: PC register load enable.
- `if_id_go` out 1: IF/ID advance.
- `if_id_clear` out 1: IF/ID loads zero (NOP).
- `id_ex_go` out 1: ID/EX advance.
- `id_ex_clear` out 1: ID/EX loads zero (bubble).
- `ex_mem_go` out 1: EX/MEM advance.
- `mem_wb_go` out 1: MEM/WB advance.
- `state` out 2: 0 = RUN, 1 = HALT, 2 = STEP.
- `cycle_cnt` out 32, `stall_cnt` out 16, `flush_cnt` out 16: statistics (see Configuration).

## Operation
- State register reset value: RUN. Transitions:
  - RUN to HALT when `halt_req`.
  - HALT to RUN on `resume`.
  - HALT to STEP on `step`.
  - STEP to RUN on `resume`; otherwise STEP to HALT unconditionally after one cycle, including when `halt_req` is asserted.
- `resume` and `step` asserted together: `resume` wins. `halt_req` is ignored in HALT. `step` is ignored in RUN and STEP.
- Active cycle (state RUN or STEP, `rst` low): defaults are `pc_en` = all `*_go` = 1 and clears = 0.
- Load-use hazard `lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt))`:
  - Drives `pc_en` = 0, `if_id_go` = 0, `id_ex_clear` = 1.
  - `id_ex_go`, `ex_mem_go` and `mem_wb_go` stay 1.
- Taken branch: `if_id_clear` = 1 and `id_ex_clear` = 1, with `pc_en` = 1 so the target loads.
  - Branch has priority over `lu`: when both are active, `lu` is suppressed and the branch response applies.
- `halt_req` in an active cycle does not gate that cycle's strobes; the syscall retires forward and the halt takes effect next cycle.
- HALT: all `go` = 0, `pc_en` = 0, clears = 0; pipeline contents are frozen.
- `rst` high overrides everything:
  - `pc_en` = 0, `if_id_go` = `id_ex_go` = 1, `if_id_clear` = `id_ex_clear` = 1, `ex_mem_go` = `mem_wb_go` = 0.
  - State returns to RUN at the clock edge.

## Timing
- All strobes are combinational from the current state and the hazard inputs, so they are valid in the same cycle for the buffers' posedge.
- `state` is registered, so a transition is visible one cycle after the request.
- Load-use inserts exactly one bubble: the next cycle has `ex_mem_read` = 0 for the bubble, so `lu` deasserts.
- Branch flush costs 2 cycles: the IF/ID and ID/EX contents are squashed.
- STEP is exactly one active cycle between two HALT cycles.
- `rst` asserted mid-stall or mid-STEP applies the reset strobes that same cycle, and RUN follows the next cycle.

## Configuration
- `PIPE_STAT_EN` defined:
  - `cycle_cnt` increments on every active cycle.
  - `stall_cnt` increments on every cycle with `lu` acting, i.e. not suppressed by branch.
  - `flush_cnt` increments on every active cycle with `branch_taken`.
  - All three saturate at all-ones and clear to 0 on `rst`.
  - HALT cycles count nowhere.
- `PIPE_STAT_EN` undefined: the counters are not built, and the three ports are tied to 0; the port list is unchanged.

## Test plan
- Reset: hold `rst` 2 cycles, then release.
  - Required during reset: `pc_en` = 0, both clears = 1, `ex_mem_go` = 0.
  - Required next cycle: `state` = 0 and all `go` = 1.
- Load-use: `ex_mem_read` = 1, `ex_rt` = 8, `id_rs` = 8.
  - Required: `pc_en` = 0, `if_id_go` = 0, `id_ex_clear` = 1 for exactly one cycle.
  - Repeat with `ex_rt` = 0: no stall.
- Branch plus load-use in the same cycle.
  - Required: `if_id_clear` = `id_ex_clear` = 1, `pc_en` = 1, `if_id_go` = 1.
  - Required: `flush_cnt` +1, `stall_cnt` unchanged.
- Halt/step: `halt_req` in RUN.
  - Required: that cycle all `go` = 1; next cycle `state` = 1 with all `go` = 0.
  - Then `step` pulse: one cycle `state` = 2 with `go` = 1, then `state` = 1.
- Priority: `step` and `resume` together in HALT.
  - Required: `state` = 0 next cycle.
  - `halt_req` in STEP: `state` = 1 next cycle.
- Counters (`PIPE_STAT_EN`): 10 active cycles, 3 HALT cycles, 2 stalls.
  - Required: `cycle_cnt` = 10, `stall_cnt` = 2.
  - Preload near 0xFFFF: `stall_cnt` saturates at 0xFFFF.
